psum_collector: RTL
===================

// Module: psum_collector
// PURPOSE
//  Receiving end of the PE-array partial-sum path. Captures one psum per column on each
//  valid beat from the array's psum outputs and accumulates the beats over a programmable
//  number of passes. It then drains the per-column totals, one column per beat, over a
//  valid/ready stream toward the global buffer write port.
// PARAMETERS
//  PE_WIDTH    4   width of each incoming psum (unsigned)
//  NUM_COLS    3   number of array columns / accumulators
//  ACC_WIDTH   16  accumulator and output width; must be >= PE_WIDTH
//  PASS_W      8   width of num_passes
//  COL_W       $clog2(NUM_COLS) (min 1) width of out_col
// PORTS
//  clk         in   1                  clock; all logic on rising edge
//  rst         in   1                  synchronous, active-low reset
//  start       in   1                  one-cycle pulse; begins a run, only accepted in IDLE
//  num_passes  in   PASS_W             beats to accumulate; sampled on accepted start
//  psum_IN     in   [PE_WIDTH-1:0] x NUM_COLS  unpacked, per-column psum from array
//  psum_valid  in   1                  psum_IN holds a valid beat this cycle
//  psum_ready  out  1                  collector accepts a beat this cycle
//  out_data    out  ACC_WIDTH          accumulated total for out_col
//  out_col     out  COL_W              column index of out_data
//  out_last    out  1                  out_col == NUM_COLS-1
//  out_valid   out  1                  drain beat present
//  out_ready   in   1                  downstream accepts the drain beat
//  busy        out  1                  state != IDLE
//  sat_flag    out  1                  sticky: an accumulator saturated this run
//  drop_err    out  1                  sticky: psum_valid seen while psum_ready=0
// BEHAVIOUR
//  Reset (rst=0 at edge): state IDLE; all accumulators, counters and outputs 0
//   (psum_ready, out_valid, busy, sat_flag, drop_err = 0). Reset aborts any run with no output.
//  FSM IDLE -> ACCUM -> DRAIN -> IDLE.
//   IDLE: psum_ready=0. When start=1, clear accumulators, pass_cnt, sat_flag and drop_err;
//    latch num_passes (0 treated as 1); go to ACCUM next cycle.
//   ACCUM: psum_ready=1. A beat is psum_valid & psum_ready. On each beat, for every column c:
//    acc[c] <= sat(acc[c] + zero_ext(psum_IN[c])), then pass_cnt++. The beat where
//    pass_cnt == latched_passes-1 updates acc and moves to DRAIN with col_idx=0.
//   DRAIN: psum_ready=0; out_valid=1; out_data=acc[col_idx]; out_col=col_idx;
//    out_last=(col_idx==NUM_COLS-1). On out_valid & out_ready: col_idx++; if out_last, go to IDLE.
//    While out_ready=0, out_data, out_col and out_last are held stable.
//  Latency: first out_valid appears 1 cycle after the final accepted psum beat.
//   With out_ready tied high, the run ends NUM_COLS cycles later.
//  Saturation: a sum > 2^ACC_WIDTH-1 clamps to all-ones and sets sat_flag.
//   sat_flag is sticky until the next accepted start.
//  psum_valid=1 while psum_ready=0 (IDLE or DRAIN): the beat is discarded, accumulators are
//   unchanged, and drop_err is set. drop_err is sticky until the next accepted start.
//  start outside IDLE is ignored; the run in progress is unaffected.
//  start and psum_valid in the same IDLE cycle: start is taken; the beat is dropped (drop_err=1).
//   Because start also clears drop_err, the set wins in that cycle.
//  out_valid never deasserts without a handshake, except on reset.
// TESTING
//  1 passes=2, psum {1,2,3} then {4,5,6} -> out (col,data) = (0,5),(1,7),(2,9); out_last only on col 2.
//  2 same run, out_ready=0 for 3 cycles on col 1 -> out_data=7 and out_col=1 held; then (2,9).
//  3 ACC_WIDTH=5, passes=4, psum 15 every column -> data 31 for all cols, sat_flag=1.
//  4 psum_valid=1 in IDLE -> drop_err=1, later run totals unaffected; next start clears drop_err.
//  5 rst=0 during DRAIN col 1 -> next cycle out_valid=0, busy=0, no further beats.
//  6 passes=0, single beat {7,0,9} -> drains 7,0,9; start pulsed mid-ACCUM is ignored.

Source files
------------

// File: rtl/psum_collector_if.sv
// Partial-sum collector bus: per-column psum input stream and per-column drain stream.
// Both streams are valid/ready: a beat transfers on a rising edge where valid and ready are both high.
interface psum_collector_if #(
    parameter int PE_WIDTH  = 4,
    parameter int NUM_COLS  = 3,
    parameter int ACC_WIDTH = 16,
    parameter int COL_W     = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
);
    logic [PE_WIDTH-1:0]  psum_IN [NUM_COLS];
    logic                 psum_valid;
    logic                 psum_ready;
    logic [ACC_WIDTH-1:0] out_data;
    logic [COL_W-1:0]     out_col;
    logic                 out_last;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output psum_IN, psum_valid, out_ready,
        input  psum_ready, out_data, out_col, out_last, out_valid
    );

    modport slave (
        input  psum_IN, psum_valid, out_ready,
        output psum_ready, out_data, out_col, out_last, out_valid
    );
endinterface

// File: rtl/psum_collector.sv
// Accumulates per-column psum beats over a programmable number of passes, then drains
// the saturated column totals one column per beat.
module psum_collector #(
    parameter int PE_WIDTH  = 4,
    parameter int NUM_COLS  = 3,
    parameter int ACC_WIDTH = 16,
    parameter int PASS_W    = 8,
    parameter int COL_W     = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PASS_W-1:0] num_passes,
    psum_collector_if.slave   bus,
    output logic              busy,
    output logic              sat_flag,
    output logic              drop_err,
    output logic [1:0]        dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;

    state_t               r_state;
    logic [ACC_WIDTH-1:0] r_acc [NUM_COLS];
    logic [PASS_W-1:0]    r_pass_cnt;
    logic [PASS_W-1:0]    r_passes;
    logic [COL_W-1:0]     r_col;
    logic                 r_psum_ready;
    logic                 r_out_valid;
    logic                 r_busy;
    logic                 r_sat;
    logic                 r_drop;

    logic [ACC_WIDTH:0]   w_sum [NUM_COLS];
    logic [NUM_COLS-1:0]  w_ovf;
    logic                 w_beat;
    logic                 w_last_pass;
    logic                 w_last_col;

    // One extra bit of sum width: the carry out is exactly the saturation condition.
    always_comb begin
        for (int c = 0; c < NUM_COLS; c++) begin
            w_sum[c] = {1'b0, r_acc[c]} + (ACC_WIDTH+1)'(bus.psum_IN[c]);
            w_ovf[c] = w_sum[c][ACC_WIDTH];
        end
    end

    assign w_beat      = bus.psum_valid & r_psum_ready;
    assign w_last_pass = (r_pass_cnt == r_passes - PASS_W'(1));
    assign w_last_col  = (r_col == COL_W'(NUM_COLS - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            for (int c = 0; c < NUM_COLS; c++) r_acc[c] <= '0;
            r_pass_cnt   <= '0;
            r_passes     <= '0;
            r_col        <= '0;
            r_psum_ready <= 1'b0;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_sat        <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int c = 0; c < NUM_COLS; c++) r_acc[c] <= '0;
                        r_pass_cnt   <= '0;
                        r_passes     <= (num_passes == '0) ? PASS_W'(1) : num_passes;
                        r_sat        <= 1'b0;
                        r_drop       <= 1'b0;
                        r_psum_ready <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_beat) begin
                        for (int c = 0; c < NUM_COLS; c++) begin
                            r_acc[c] <= w_ovf[c] ? ACC_MAX : w_sum[c][ACC_WIDTH-1:0];
                        end
                        if (|w_ovf) r_sat <= 1'b1;
                        r_pass_cnt <= r_pass_cnt + PASS_W'(1);
                        if (w_last_pass) begin
                            r_col        <= '0;
                            r_psum_ready <= 1'b0;
                            r_out_valid  <= 1'b1;
                            r_state      <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (bus.out_ready) begin
                        if (w_last_col) begin
                            r_out_valid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // Placed after the start clear so a dropped beat in the start cycle still sets it.
            if (bus.psum_valid && !r_psum_ready) r_drop <= 1'b1;
        end
    end

    assign bus.psum_ready = r_psum_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_valid ? r_acc[r_col] : '0;
    assign bus.out_col    = r_col;
    assign bus.out_last   = r_out_valid & w_last_col;
    assign busy           = r_busy;
    assign sat_flag       = r_sat;
    assign drop_err       = r_drop;
    assign dbg_state      = r_state;
endmodule
